// File: rtl/dac_sample_sched.sv
// dac_sample_sched: 48 kHz sample tick, soft-mute fade gain and SPI DAC issue scheduler
//   clk, reset          system clock, synchronous active-high reset
//   in_data, in_valid   offset-binary audio sample into the hold register (latest wins)
//   mute                level; 1 fades out and holds midscale
//   dac_busy            SPI driver busy; a tick seen while busy is dropped
//   dac_data, dac_go    sample and one-cycle start strobe to the SPI driver
//   tick                one-cycle sample-rate strobe
//   fade_state          0 MUTED, 1 FADE_IN, 2 PLAY, 3 FADE_OUT
//   overrun_cnt         saturating count of dropped ticks
//   SAW_TEST_EN         adds test_mode: internal sawtooth (+64 per tick) replaces the hold register
`timescale 1ns/1ps
module dac_sample_sched #(
  parameter int F_CLK    = 50_000_000,
  parameter int F_S      = 48_000,
  parameter int SIG_BITS = 16,
  parameter int G_BITS   = 8
) (
  input  logic                clk,
  input  logic                reset,
`ifdef SAW_TEST_EN
  input  logic                test_mode,
`endif
  input  logic [SIG_BITS-1:0] in_data,
  input  logic                in_valid,
  input  logic                mute,
  input  logic                dac_busy,
  output logic [SIG_BITS-1:0] dac_data,
  output logic                dac_go,
  output logic                tick,
  output logic [1:0]          fade_state,
  output logic [7:0]          overrun_cnt
);
  localparam int N  = F_CLK / F_S;
  localparam int CW = $clog2(N);
  localparam int PW = SIG_BITS + G_BITS + 1;
  localparam logic [SIG_BITS-1:0] MID  = {1'b1, {(SIG_BITS-1){1'b0}}};
  localparam logic [G_BITS:0]     FULL = {1'b1, {G_BITS{1'b0}}};
  typedef enum logic [1:0] {MUTED, FADE_IN, PLAY, FADE_OUT} state_t;
  state_t state_q, state_d, s_nx;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [G_BITS:0] gain_q, gain_d, g_nx;
  logic [SIG_BITS-1:0] hold_q, hold_d, data_q, data_d, src;
  logic signed [PW-1:0] prod_q, prod_d;
  logic pend_q, pend_d, go_q, go_d, tick_w;
  logic [7:0] ov_q, ov_d;
  // in_valid on the tick cycle bypasses the hold register so the new sample is used
  assign hold_d = in_valid ? in_data : hold_q;
`ifdef SAW_TEST_EN
  logic [SIG_BITS-1:0] saw_q, saw_d;
  assign saw_d = tick_w ? saw_q + SIG_BITS'(64) : saw_q;
  assign src = test_mode ? saw_q : hold_d;
  always_ff @(posedge clk) saw_q <= reset ? '0 : saw_d;
`else
  assign src = hold_d;
`endif
  always_comb begin
    tick_w = cnt_q == CW'(N - 1);
    cnt_d = tick_w ? '0 : cnt_q + 1'b1;
    // fade steps saturate at both ends so a reversal at gain 0 or full gain stays in range
    g_nx = state_q == MUTED ? '0 :
           state_q == PLAY ? (mute ? FULL - 1'b1 : FULL) :
           mute ? (gain_q == '0 ? '0 : gain_q - 1'b1) :
                  (gain_q == FULL ? FULL : gain_q + 1'b1);
    s_nx = state_q == MUTED ? (mute ? MUTED : FADE_IN) :
           g_nx == '0 ? MUTED : g_nx == FULL ? PLAY : mute ? FADE_OUT : FADE_IN;
    state_d = tick_w ? s_nx : state_q;
    gain_d = tick_w ? g_nx : gain_q;
    // offset-binary to two's complement by flipping the MSB, then signed multiply by gain
    prod_d = tick_w ? PW'($signed(src ^ MID)) * PW'($signed({1'b0, g_nx})) : prod_q;
    pend_d = tick_w & ~dac_busy;
    ov_d = tick_w & dac_busy & (ov_q != 8'hFF) ? ov_q + 8'd1 : ov_q;
    go_d = pend_q;
    data_d = pend_q ? SIG_BITS'(prod_q >>> G_BITS) ^ MID : data_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      state_q <= MUTED;
      gain_q <= '0;
      hold_q <= MID;
      prod_q <= '0;
      pend_q <= 1'b0;
      go_q <= 1'b0;
      data_q <= MID;
      ov_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      state_q <= state_d;
      gain_q <= gain_d;
      hold_q <= hold_d;
      prod_q <= prod_d;
      pend_q <= pend_d;
      go_q <= go_d;
      data_q <= data_d;
      ov_q <= ov_d;
    end
  end
  assign dac_data = data_q;
  assign dac_go = go_q;
  assign tick = tick_w;
  assign fade_state = state_q;
  assign overrun_cnt = ov_q;
endmodule

// File: tb/tb_dac_sample_sched.sv
// tb_dac_sample_sched: random and directed stimulus against a behavioural sample/fade model
`timescale 1ns/1ps
module tb_dac_sample_sched;
  localparam int N = 37;
  logic clk = 1'b0;
  logic reset, in_valid, mute, dac_busy, dac_go, tick;
  logic [15:0] in_data, dac_data, d;
  logic [1:0] fade_state;
  logic [7:0] overrun_cnt;
  int n_chk = 0, n_err = 0, c;
  int m_k, m_state, m_gain, m_hold, m_ov, pend_at, pend_val, e_tick, e_go, e_data;
  bit m_valid = 0;
`ifdef SAW_TEST_EN
  logic test_mode = 1'b0;
`endif
  always #5 clk = ~clk;
  dac_sample_sched #(.F_CLK(1_776_100), .F_S(48_000)) dut (
    .clk(clk), .reset(reset),
`ifdef SAW_TEST_EN
    .test_mode(test_mode),
`endif
    .in_data(in_data), .in_valid(in_valid), .mute(mute), .dac_busy(dac_busy),
    .dac_data(dac_data), .dac_go(dac_go), .tick(tick), .fade_state(fade_state),
    .overrun_cnt(overrun_cnt));
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic sync;
    @(posedge clk);
    #2;
  endtask
  task automatic wait_go(output logic [15:0] dd, output int cc);
    cc = 0;
    dd = 'x;
    while (cc < 3 * N) begin
      @(negedge clk);
      cc++;
      if (dac_go) begin
        dd = dac_data;
        return;
      end
    end
    chk("go_timeout", 0, 1);
  endtask
  task automatic wait_tick;
    for (int i = 0; i < 2 * N; i++) begin
      @(negedge clk);
      if (tick) return;
    end
    chk("tick_timeout", 0, 1);
  endtask
  // Model: inputs are stable at the negedge and sampled at the following posedge,
  // so each negedge first checks the current cycle, then predicts the next one.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("tick", int'(tick), e_tick);
      chk("dac_go", int'(dac_go), e_go);
      chk("dac_data", int'(dac_data), e_data);
      chk("fade_state", int'(fade_state), m_state);
      chk("overrun_cnt", int'(overrun_cnt), m_ov);
    end
    if (reset) begin
      m_valid = 1;
      m_k = 0; m_state = 0; m_gain = 0; m_hold = 32768; m_ov = 0;
      pend_at = -1; e_tick = 0; e_go = 0; e_data = 32768;
    end else if (m_valid) begin
      if (m_k % N == N - 1) begin
        int src, g, p;
        src = in_valid ? int'(in_data) : m_hold;
        if (m_state == 0) begin
          g = 0;
          m_state = mute ? 0 : 1;
        end else if (m_state == 2 && mute) begin
          g = 255;
          m_state = 3;
        end else begin
          g = m_gain + (mute ? -1 : 1);
          g = g < 0 ? 0 : g > 256 ? 256 : g;
          m_state = g == 0 ? 0 : g == 256 ? 2 : mute ? 3 : 1;
        end
        m_gain = g;
        p = (src - 32768) * g;
        if (dac_busy) m_ov = m_ov < 255 ? m_ov + 1 : 255;
        else begin
          pend_at = m_k + 2;
          pend_val = (p >>> 8) + 32768;
        end
      end
      if (in_valid) m_hold = int'(in_data);
      m_k++;
      e_tick = (m_k % N == N - 1) ? 1 : 0;
      e_go = (pend_at == m_k) ? 1 : 0;
      if (e_go) e_data = pend_val;
    end
  end
  initial begin
    #950_000;
    $display("FAIL watchdog: run did not end, limit 95000 cycles");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1; mute = 1; in_data = 16'hC000; in_valid = 1; dac_busy = 0;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    chk("rst_data", int'(dac_data), 16'h8000);
    chk("rst_go", int'(dac_go), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_state", int'(fade_state), 0);
    chk("rst_ov", int'(overrun_cnt), 0);
    wait_go(d, c);
    chk("first_go_latency", c, N + 1);
    chk("muted_data", int'(d), 16'h8000);
    wait_go(d, c);
    chk("go_period", c, N);
    sync; mute = 0;
    wait_go(d, c);
    chk("unmute_tick_data", int'(d), 16'h8000);
    wait_go(d, c);
    chk("fade_in_1", int'(d), 16'h8040);
    chk("fade_in_1_state", int'(fade_state), 1);
    for (int i = 2; i <= 256; i++) wait_go(d, c);
    chk("fade_in_256", int'(d), 16'hC000);
    chk("play_state", int'(fade_state), 2);
    wait_go(d, c);
    chk("play_exact", int'(d), 16'hC000);
    sync; mute = 1;
    wait_go(d, c);
    chk("fade_out_1", int'(d), 16'hBFC0);
    chk("fade_out_state", int'(fade_state), 3);
    repeat (255) wait_go(d, c);
    chk("fade_out_end", int'(d), 16'h8000);
    chk("muted_state", int'(fade_state), 0);
    sync; in_data = 16'h0000; mute = 0;
    wait_go(d, c);
    wait_go(d, c);
    chk("neg_fs_floor", int'(d), 16'h7F80);
    sync; in_data = 16'hC000;
    for (int i = 0; i < 300 && fade_state != 2; i++) wait_go(d, c);
    chk("reach_play", int'(fade_state), 2);
    sync; mute = 1;
    repeat (10) wait_go(d, c);
    chk("fade_out_10", int'(d), 16'hBD80);
    sync; mute = 0;
    wait_go(d, c);
    chk("resume_247", int'(d), 16'hBDC0);
    chk("resume_state", int'(fade_state), 1);
    sync; dac_busy = 1;
    repeat (3) wait_tick;
    sync; dac_busy = 0;
    chk("overrun_3", int'(overrun_cnt), 3);
    wait_go(d, c);
    chk("gain_after_drop", int'(d), 16'hBEC0);
    sync; dac_busy = 1;
    repeat (300) wait_tick;
    sync; dac_busy = 0;
    chk("overrun_sat", int'(overrun_cnt), 255);
    wait_tick;
    sync; reset = 1;
    sync; reset = 0;
    @(negedge clk);
    chk("mid_rst_data", int'(dac_data), 16'h8000);
    chk("mid_rst_go", int'(dac_go), 0);
    chk("mid_rst_state", int'(fade_state), 0);
    chk("mid_rst_ov", int'(overrun_cnt), 0);
    c = 0;
    repeat (5) begin
      @(negedge clk);
      if (dac_go) c++;
    end
    chk("cancelled_go", c, 0);
    for (int i = 0; i < 12000; i++) begin
      sync;
      in_valid = ($urandom % 4) == 0;
      in_data = 16'($urandom);
      dac_busy = ($urandom % 5) == 0;
      if ($urandom % 500 == 0) mute = ~mute;
      reset = ($urandom % 6000) == 0;
    end
    sync; reset = 0;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
